// File: rtl/bus_rr_scheduler.sv
// bus_rr_scheduler
// Round-robin scheduler that moves one packet at a time from a set of source
// FIFOs onto a shared bus. The top byte of each packet is the destination ID.
// A packet goes to one device, or to every device except its source
// (broadcast). It is dropped if the ID is unusable or if backpressure
// outlasts the timeout.
//
// Ports:
//   clk        single clock, all logic on the rising edge
//   reset      synchronous, active-high reset
//   pndng      per-device "FIFO non-empty" flags
//   D_pop      per-device FIFO head data, device i at [i*pckg_sz +: pckg_sz]
//   full       per-device receive-FIFO full flags (backpressure)
//   pop        one-hot, single-cycle pop strobe to the granted source
//   push       single-cycle push strobe to every target of the packet
//   D_push     shared bus data, valid while any push bit is high, held otherwise
//   grant_id   index of the current or most recently granted source
//   busy       high whenever the scheduler is not idle
//   drop_cnt   saturating count of dropped packets
module bus_rr_scheduler #(
  parameter int         drvrs     = 4,
  parameter int         pckg_sz   = 16,
  parameter logic [7:0] broadcast = {8{1'b1}},
  parameter int         tmo       = 64
) (
  input  logic                                   clk,
  input  logic                                   reset,
  input  logic [drvrs-1:0]                       pndng,
  input  logic [drvrs*pckg_sz-1:0]               D_pop,
  input  logic [drvrs-1:0]                       full,
  output logic [drvrs-1:0]                       pop,
  output logic [drvrs-1:0]                       push,
  output logic [pckg_sz-1:0]                     D_push,
  output logic [((drvrs > 1) ? $clog2(drvrs) : 1)-1:0] grant_id,
  output logic                                   busy,
  output logic [15:0]                            drop_cnt
);

  localparam int GRANT_W = (drvrs > 1) ? $clog2(drvrs) : 1;
  localparam int WAIT_W  = $clog2(tmo + 1);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_POP   = 3'd1;
  localparam logic [2:0] S_ROUTE = 3'd2;
  localparam logic [2:0] S_WAIT  = 3'd3;
  localparam logic [2:0] S_PUSH  = 3'd4;

  logic [2:0]         state_q, state_d;
  logic [GRANT_W-1:0] grant_id_q, grant_id_d;
  logic [GRANT_W-1:0] last_grant_q, last_grant_d;
  logic [pckg_sz-1:0] packet_q, packet_d;
  logic [pckg_sz-1:0] d_push_q, d_push_d;
  logic [15:0]        drop_cnt_q, drop_cnt_d;
  logic [WAIT_W-1:0]  wait_cnt_q, wait_cnt_d;

  logic               sel_found;
  logic [GRANT_W-1:0] sel_idx;
  logic [pckg_sz-1:0] pop_data;
  logic [7:0]         dest;
  logic [drvrs-1:0]   mask;
  logic               route_drop;
  logic               blocked;
  logic [15:0]        drop_cnt_inc;

  // Round-robin pick. Indices above the last grant are searched first, then
  // the ones at or below it, which gives the wrap-around order without modulo.
  always_comb begin
    sel_found = 1'b0;
    sel_idx   = '0;
    for (int i = 0; i < drvrs; i++) begin
      if (!sel_found && (i > int'(last_grant_q)) && pndng[i]) begin
        sel_found = 1'b1;
        sel_idx   = GRANT_W'(i);
      end
    end
    for (int i = 0; i < drvrs; i++) begin
      if (!sel_found && (i <= int'(last_grant_q)) && pndng[i]) begin
        sel_found = 1'b1;
        sel_idx   = GRANT_W'(i);
      end
    end
  end

  // Head data of the granted source, captured into the packet register in POP.
  always_comb begin
    pop_data = '0;
    for (int i = 0; i < drvrs; i++) begin
      if (int'(grant_id_q) == i) pop_data = D_pop[i*pckg_sz +: pckg_sz];
    end
  end

  // Target mask of the held packet. The source is never a target, so an empty
  // mask covers both an unusable ID and a broadcast with no other devices.
  always_comb begin
    dest = packet_q[pckg_sz-1 -: 8];
    mask = '0;
    for (int i = 0; i < drvrs; i++) begin
      if (dest == broadcast) begin
        mask[i] = (i != int'(grant_id_q));
      end else if ((int'(dest) == i) && (i != int'(grant_id_q))) begin
        mask[i] = 1'b1;
      end
    end
    route_drop   = (mask == '0);
    blocked      = |(full & mask);
    drop_cnt_inc = (drop_cnt_q == 16'hFFFF) ? drop_cnt_q : drop_cnt_q + 16'd1;
  end

  // Next-state logic. A dropped packet moves last_grant exactly as a delivered
  // one does, so the dropping source loses priority.
  always_comb begin
    state_d      = state_q;
    grant_id_d   = grant_id_q;
    last_grant_d = last_grant_q;
    packet_d     = packet_q;
    d_push_d     = d_push_q;
    drop_cnt_d   = drop_cnt_q;
    wait_cnt_d   = wait_cnt_q;
    case (state_q)
      S_IDLE: begin
        if (sel_found) begin
          grant_id_d = sel_idx;
          state_d    = S_POP;
        end
      end
      S_POP: begin
        packet_d = pop_data;
        state_d  = S_ROUTE;
      end
      S_ROUTE: begin
        if (route_drop) begin
          drop_cnt_d   = drop_cnt_inc;
          last_grant_d = grant_id_q;
          state_d      = S_IDLE;
        end else if (!blocked) begin
          d_push_d = packet_q;
          state_d  = S_PUSH;
        end else begin
          wait_cnt_d = '0;
          state_d    = S_WAIT;
        end
      end
      S_WAIT: begin
        if (!blocked) begin
          d_push_d = packet_q;
          state_d  = S_PUSH;
        end else if (wait_cnt_q == WAIT_W'(tmo - 1)) begin
          drop_cnt_d   = drop_cnt_inc;
          last_grant_d = grant_id_q;
          state_d      = S_IDLE;
        end else begin
          wait_cnt_d = wait_cnt_q + 1'b1;
        end
      end
      S_PUSH: begin
        last_grant_d = grant_id_q;
        state_d      = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State registers. Reset abandons any packet in flight without counting a
  // drop, and last_grant restarts at the top index so that device 0 is
  // searched first.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= S_IDLE;
      grant_id_q   <= '0;
      last_grant_q <= GRANT_W'(drvrs - 1);
      packet_q     <= '0;
      d_push_q     <= '0;
      drop_cnt_q   <= '0;
      wait_cnt_q   <= '0;
    end else begin
      state_q      <= state_d;
      grant_id_q   <= grant_id_d;
      last_grant_q <= last_grant_d;
      packet_q     <= packet_d;
      d_push_q     <= d_push_d;
      drop_cnt_q   <= drop_cnt_d;
      wait_cnt_q   <= wait_cnt_d;
    end
  end

  // Strobes are decoded from the state, so pop and push can never coincide.
  always_comb begin
    pop = '0;
    for (int i = 0; i < drvrs; i++) begin
      if (state_q == S_POP) pop[i] = (int'(grant_id_q) == i);
    end
    push = (state_q == S_PUSH) ? mask : '0;
  end

  assign D_push   = d_push_q;
  assign grant_id = grant_id_q;
  assign busy     = (state_q != S_IDLE);
  assign drop_cnt = drop_cnt_q;

endmodule

// File: tb/tb_bus_rr_scheduler.sv
// tb_bus_rr_scheduler
// Self-checking bench for bus_rr_scheduler with 4 devices, 16-bit packets and
// a 64-cycle timeout. A reference model works out the grant order from "first
// requester after the last grant, modulo 4" and the targets from the
// destination byte. Each scenario task drives its stimulus and checks the
// results against that model or against constants.
module tb_bus_rr_scheduler;

  localparam int DRVRS = 4;
  localparam int PSZ   = 16;
  localparam int TMO   = 64;

  logic                 clk = 1'b0;
  logic                 reset = 1'b1;
  logic [DRVRS-1:0]     pndng = '0;
  logic [DRVRS*PSZ-1:0] d_pop = '0;
  logic [DRVRS-1:0]     full = '0;
  logic [DRVRS-1:0]     pop;
  logic [DRVRS-1:0]     push;
  logic [PSZ-1:0]       d_push;
  logic [1:0]           grant_id;
  logic                 busy;
  logic [15:0]          drop_cnt;

  int n_checks = 0;
  int n_fails  = 0;
  int model_last;
  int model_drops;

  bus_rr_scheduler #(.drvrs(DRVRS), .pckg_sz(PSZ), .broadcast(8'hFF), .tmo(TMO)) dut (
    .clk(clk), .reset(reset), .pndng(pndng), .D_pop(d_pop), .full(full),
    .pop(pop), .push(push), .D_push(d_push), .grant_id(grant_id),
    .busy(busy), .drop_cnt(drop_cnt)
  );

  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  // Advance one cycle and settle just after the rising edge.
  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Reference arbiter: the first requester after 'last', with wrap-around.
  function automatic int model_pick(input logic [3:0] req, input int last);
    for (int k = 1; k <= DRVRS; k++) begin
      if (req[(last + k) % DRVRS]) return (last + k) % DRVRS;
    end
    return -1;
  endfunction

  // Reference router: broadcast goes to everyone but the source, a valid ID
  // other than the source goes to that device, and anything else is dropped.
  function automatic logic [3:0] model_targets(input int src, input logic [15:0] pkt);
    int dest;
    dest = int'(pkt[15:8]);
    if (dest == 255) return 4'b1111 & ~(4'b0001 << src);
    if (dest < DRVRS && dest != src) return 4'b0001 << dest;
    return 4'b0000;
  endfunction

  task automatic test_reset;
    reset = 1'b1; pndng = 4'b1111; full = '0; d_pop = '0;
    tick; tick;
    n_checks++; if (pop !== 4'b0) begin n_fails++; $display("[TB] FAIL rst_pop: got %b want 0000", pop); end
    n_checks++; if (push !== 4'b0) begin n_fails++; $display("[TB] FAIL rst_push: got %b want 0000", push); end
    n_checks++; if (d_push !== 16'h0) begin n_fails++; $display("[TB] FAIL rst_dpush: got %h want 0000", d_push); end
    n_checks++; if (grant_id !== 2'd0) begin n_fails++; $display("[TB] FAIL rst_grant: got %0d want 0", grant_id); end
    n_checks++; if (busy !== 1'b0) begin n_fails++; $display("[TB] FAIL rst_busy: got %b want 0", busy); end
    n_checks++; if (drop_cnt !== 16'h0) begin n_fails++; $display("[TB] FAIL rst_drop: got %0d want 0", drop_cnt); end
    pndng = '0; reset = 1'b0;
    model_last = DRVRS - 1; model_drops = 0;
  endtask

  task automatic test_reset_in_wait;
    bit seen_push;
    d_pop[0 +: 16] = 16'h02C3; full = 4'b0100; pndng = 4'b0001;
    tick;
    pndng = '0;
    tick; tick; tick;
    n_checks++; if (busy !== 1'b1) begin n_fails++; $display("[TB] FAIL riw_busy_wait: got %b want 1", busy); end
    reset = 1'b1;
    tick;
    n_checks++; if (pop !== 4'b0) begin n_fails++; $display("[TB] FAIL riw_pop: got %b want 0000", pop); end
    n_checks++; if (push !== 4'b0) begin n_fails++; $display("[TB] FAIL riw_push: got %b want 0000", push); end
    n_checks++; if (busy !== 1'b0) begin n_fails++; $display("[TB] FAIL riw_busy: got %b want 0", busy); end
    n_checks++; if (drop_cnt !== 16'(model_drops)) begin n_fails++; $display("[TB] FAIL riw_drop: got %0d want %0d", drop_cnt, model_drops); end
    reset = 1'b0; full = '0;
    model_last = DRVRS - 1; model_drops = 0;
    seen_push = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick;
      if (push !== 4'b0) seen_push = 1'b1;
    end
    n_checks++; if (seen_push !== 1'b0) begin n_fails++; $display("[TB] FAIL riw_no_delivery: push seen=%b want 0", seen_push); end
    // The first grant after reset goes to the lowest pending index.
    d_pop[16 +: 16] = 16'h00D4; d_pop[48 +: 16] = 16'h0011; pndng = 4'b1010;
    tick;
    n_checks++; if (pop !== 4'b0010) begin n_fails++; $display("[TB] FAIL riw_first_pop: got %b want 0010", pop); end
    n_checks++; if (grant_id !== 2'd1) begin n_fails++; $display("[TB] FAIL riw_first_grant: got %0d want 1", grant_id); end
    pndng = '0;
    tick; tick;
    n_checks++; if (push !== 4'b0001) begin n_fails++; $display("[TB] FAIL riw_after_push: got %b want 0001", push); end
    tick;
    model_last = 1;
  endtask

  task automatic test_round_robin;
    logic [15:0] pkt [DRVRS];
    int g;
    logic [3:0] exp_mask;
    for (int i = 0; i < DRVRS; i++) begin
      pkt[i] = {8'((i + 1) % DRVRS), 8'(8'h50 + i)};
      d_pop[i*PSZ +: PSZ] = pkt[i];
    end
    pndng = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      g = model_pick(4'b1111, model_last);
      exp_mask = model_targets(g, pkt[g]);
      tick;
      n_checks++; if (pop !== (4'b0001 << g)) begin n_fails++; $display("[TB] FAIL rr_pop[%0d]: got %b want %b", k, pop, 4'b0001 << g); end
      n_checks++; if (grant_id !== 2'(g)) begin n_fails++; $display("[TB] FAIL rr_grant[%0d]: got %0d want %0d", k, grant_id, g); end
      tick; tick;
      n_checks++; if (push !== exp_mask) begin n_fails++; $display("[TB] FAIL rr_push[%0d]: got %b want %b", k, push, exp_mask); end
      n_checks++; if (d_push !== pkt[g]) begin n_fails++; $display("[TB] FAIL rr_data[%0d]: got %h want %h", k, d_push, pkt[g]); end
      model_last = g;
      if (k == 4) pndng = '0;
      tick;
      n_checks++; if (busy !== 1'b0) begin n_fails++; $display("[TB] FAIL rr_idle[%0d]: got %b want 0", k, busy); end
    end
  endtask

  task automatic test_unicast;
    d_pop[0 +: 16] = 16'h02AB; pndng = 4'b0001;
    tick;
    n_checks++; if (pop !== 4'b0001) begin n_fails++; $display("[TB] FAIL uni_pop: got %b want 0001", pop); end
    n_checks++; if (busy !== 1'b1) begin n_fails++; $display("[TB] FAIL uni_busy: got %b want 1", busy); end
    pndng = '0;
    tick;
    d_pop[0 +: 16] = 16'h0000;
    n_checks++; if (push !== 4'b0 || pop !== 4'b0) begin n_fails++; $display("[TB] FAIL uni_route_quiet: got pop=%b push=%b want 0", pop, push); end
    tick;
    n_checks++; if (push !== 4'b0100) begin n_fails++; $display("[TB] FAIL uni_push: got %b want 0100", push); end
    n_checks++; if (d_push !== 16'h02AB) begin n_fails++; $display("[TB] FAIL uni_data: got %h want 02ab", d_push); end
    tick;
    n_checks++; if (busy !== 1'b0) begin n_fails++; $display("[TB] FAIL uni_idle: got %b want 0", busy); end
    n_checks++; if (push !== 4'b0 || d_push !== 16'h02AB) begin n_fails++; $display("[TB] FAIL uni_hold: got push=%b data=%h want 0000/02ab", push, d_push); end
    model_last = 0;
  endtask

  task automatic test_broadcast;
    int g;
    g = model_pick(4'b0010, model_last);
    d_pop[16 +: 16] = 16'hFF55; pndng = 4'b0010;
    tick;
    n_checks++; if (grant_id !== 2'(g)) begin n_fails++; $display("[TB] FAIL bc_grant: got %0d want %0d", grant_id, g); end
    pndng = '0;
    tick; tick;
    n_checks++; if (push !== 4'b1101) begin n_fails++; $display("[TB] FAIL bc_push: got %b want 1101", push); end
    n_checks++; if (d_push !== 16'hFF55) begin n_fails++; $display("[TB] FAIL bc_data: got %h want ff55", d_push); end
    tick;
    model_last = g;
  endtask

  // Table of single transactions: two drops followed by a normal delivery.
  task automatic test_drop;
    logic [3:0]  req_t [3] = '{4'b0100, 4'b1000, 4'b1001};
    logic [15:0] pkt_t [3] = '{16'h0712, 16'h03CD, 16'h0199};
    int g;
    logic [3:0] exp_mask;
    for (int r = 0; r < 3; r++) begin
      for (int i = 0; i < DRVRS; i++) d_pop[i*PSZ +: PSZ] = pkt_t[r];
      g = model_pick(req_t[r], model_last);
      exp_mask = model_targets(g, pkt_t[r]);
      pndng = req_t[r];
      tick;
      n_checks++; if (pop !== (4'b0001 << g)) begin n_fails++; $display("[TB] FAIL drop_pop[%0d]: got %b want %b", r, pop, 4'b0001 << g); end
      pndng = '0;
      tick; tick;
      if (exp_mask != 4'b0) begin
        n_checks++; if (push !== exp_mask) begin n_fails++; $display("[TB] FAIL drop_push[%0d]: got %b want %b", r, push, exp_mask); end
        tick;
      end else begin
        model_drops++;
        n_checks++; if (push !== 4'b0) begin n_fails++; $display("[TB] FAIL drop_nopush[%0d]: got %b want 0000", r, push); end
      end
      model_last = g;
      n_checks++; if (busy !== 1'b0) begin n_fails++; $display("[TB] FAIL drop_idle[%0d]: got %b want 0", r, busy); end
      n_checks++; if (drop_cnt !== 16'(model_drops)) begin n_fails++; $display("[TB] FAIL drop_cnt[%0d]: got %0d want %0d", r, drop_cnt, model_drops); end
    end
  endtask

  task automatic test_backpressure;
    int cycles;
    bit seen_push;
    // Short stall: push follows the cycle on which full falls.
    d_pop[0 +: 16] = 16'h02A1; full = 4'b0100; pndng = 4'b0001;
    tick;
    pndng = '0;
    tick; tick;
    seen_push = 1'b0;
    for (int i = 0; i < 10; i++) begin
      if (push !== 4'b0 || busy !== 1'b1) seen_push = 1'b1;
      tick;
    end
    n_checks++; if (seen_push !== 1'b0) begin n_fails++; $display("[TB] FAIL bp_stall: early push or idle=%b want 0", seen_push); end
    full = '0;
    tick;
    n_checks++; if (push !== 4'b0100) begin n_fails++; $display("[TB] FAIL bp_push: got %b want 0100", push); end
    n_checks++; if (d_push !== 16'h02A1) begin n_fails++; $display("[TB] FAIL bp_data: got %h want 02a1", d_push); end
    tick;
    model_last = 0;
    // Long stall: the packet is dropped after the timeout.
    d_pop[16 +: 16] = 16'h02B2; full = 4'b0100; pndng = 4'b0010;
    tick;
    n_checks++; if (pop !== 4'b0010) begin n_fails++; $display("[TB] FAIL bp_to_pop: got %b want 0010", pop); end
    pndng = '0;
    cycles = 0; seen_push = 1'b0;
    while (busy === 1'b1 && cycles < 200) begin
      tick;
      cycles++;
      if (push !== 4'b0) seen_push = 1'b1;
    end
    model_drops++;
    n_checks++; if (cycles != TMO + 2) begin n_fails++; $display("[TB] FAIL bp_timeout_len: got %0d cycles want %0d", cycles, TMO + 2); end
    n_checks++; if (seen_push !== 1'b0) begin n_fails++; $display("[TB] FAIL bp_timeout_push: push seen=%b want 0", seen_push); end
    n_checks++; if (drop_cnt !== 16'(model_drops)) begin n_fails++; $display("[TB] FAIL bp_timeout_cnt: got %0d want %0d", drop_cnt, model_drops); end
    full = '0;
    model_last = 1;
  endtask

  task automatic test_random;
    logic [15:0] pkt [DRVRS];
    logic [3:0] req;
    logic [3:0] exp_mask;
    logic [7:0] dest;
    int g;
    for (int t = 0; t < 60; t++) begin
      req = 4'($urandom_range(1, 15));
      for (int i = 0; i < DRVRS; i++) begin
        case ($urandom_range(0, 6))
          0, 1, 2, 3: dest = 8'($urandom_range(0, 3));
          4:          dest = 8'h04;
          5:          dest = 8'h07;
          default:    dest = 8'hFF;
        endcase
        pkt[i] = {dest, 8'($urandom)};
        d_pop[i*PSZ +: PSZ] = pkt[i];
      end
      g = model_pick(req, model_last);
      exp_mask = model_targets(g, pkt[g]);
      pndng = req;
      tick;
      n_checks++; if (pop !== (4'b0001 << g) || grant_id !== 2'(g)) begin n_fails++; $display("[TB] FAIL rnd_grant[%0d]: got pop=%b id=%0d want src %0d", t, pop, grant_id, g); end
      pndng = '0;
      tick;
      d_pop = {$urandom, $urandom};
      tick;
      if (exp_mask != 4'b0) begin
        n_checks++; if (push !== exp_mask || d_push !== pkt[g] || pop !== 4'b0) begin n_fails++; $display("[TB] FAIL rnd_push[%0d]: got %b/%h want %b/%h", t, push, d_push, exp_mask, pkt[g]); end
        tick;
      end else begin
        model_drops++;
        n_checks++; if (push !== 4'b0) begin n_fails++; $display("[TB] FAIL rnd_nopush[%0d]: got %b want 0000", t, push); end
      end
      model_last = g;
      n_checks++; if (busy !== 1'b0 || drop_cnt !== 16'(model_drops)) begin n_fails++; $display("[TB] FAIL rnd_end[%0d]: got busy=%b drops=%0d want 0/%0d", t, busy, drop_cnt, model_drops); end
    end
  endtask

  initial begin
    test_reset;
    test_reset_in_wait;
    test_reset;
    test_round_robin;
    test_unicast;
    test_broadcast;
    test_drop;
    test_backpressure;
    test_random;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule

// File: doc/bus_rr_scheduler.md
BUS_RR_SCHEDULER -- requirements
Module: bus_rr_scheduler

Interface
REQ-001 Parameter drvrs, default 4, number of attached device FIFOs.
REQ-002 Parameter pckg_sz, default 16, packet width in bits; destination ID is D_pop[pckg_sz-1 -: 8].
REQ-003 Parameter broadcast, default {8{1'b1}}, destination ID meaning all devices except the source.
REQ-004 Parameter tmo, default 64, maximum cycles the block waits on backpressure before dropping a packet.
REQ-005 clk  in  1  single clock; all logic on rising edge.
REQ-006 reset  in  1  synchronous, active-high reset.
REQ-007 pndng  in  drvrs  per-device "FIFO non-empty" flag.
REQ-008 D_pop  in  drvrs x pckg_sz  per-device FIFO head data, valid while pndng[i]=1.
REQ-009 full  in  drvrs  per-device receive-FIFO full flag (backpressure).
REQ-010 pop  out  drvrs  one-hot, 1-cycle pop strobe to the granted source FIFO.
REQ-011 push  out  drvrs  1-cycle push strobe to each target FIFO.
REQ-012 D_push  out  pckg_sz  shared bus data, valid when any push bit is 1.
REQ-013 grant_id  out  $clog2(drvrs)  index of the currently or last granted source.
REQ-014 busy  out  1  high in every state except IDLE.
REQ-015 drop_cnt  out  16  saturating count of dropped packets.

Function
REQ-016 The FSM SHALL have states IDLE, POP, ROUTE, WAIT, PUSH.
REQ-017 IDLE: if any pndng=1, select the first requester i searching from (last_grant+1) mod drvrs upward with wrap; register grant_id=i; go to POP; else stay.
REQ-018 POP: pop[grant_id]=1 for exactly this cycle; capture D_pop[grant_id] into the packet register on the same edge; go to ROUTE.
REQ-019 ROUTE: compute the target mask: broadcast ID -> all devices except the source; ID < drvrs and ID != source -> one-hot(ID); any other ID (out of range or equal to source) -> drop.
REQ-020 ROUTE: on drop, increment drop_cnt and go to IDLE; otherwise go to PUSH if (full & mask)==0, else go to WAIT with the wait counter cleared.
REQ-021 WAIT: go to PUSH on the first cycle (full & mask)==0; on reaching tmo cycles without that, drop (drop_cnt+1) and go to IDLE.
REQ-022 PUSH: push=mask and D_push=packet for exactly this cycle; last_grant<=grant_id; go to IDLE.
REQ-023 Unblocked latency SHALL be 4 cycles: pndng seen in IDLE at cycle n -> pop at n+1 -> push at n+3 -> IDLE at n+4.
REQ-024 pop and push SHALL never be asserted in the same cycle, and at most one packet SHALL be in flight.
REQ-025 last_grant SHALL update only in PUSH or on drop, so a dropped source loses priority exactly as a served one does.
REQ-026 drop_cnt SHALL saturate at 16'hFFFF and never wrap.
REQ-027 D_push SHALL hold its last value outside PUSH; push=0 there.
REQ-028 pndng deasserting after grant SHALL NOT abort the transfer; the packet captured in POP is delivered.
REQ-029 Broadcast with drvrs=1 (empty mask) SHALL be treated as a drop.

Reset
REQ-030 While reset=1 at a clock edge: state=IDLE, pop=0, push=0, D_push=0, grant_id=0, last_grant=drvrs-1, busy=0, drop_cnt=0, wait counter=0.
REQ-031 Reset in any state SHALL abandon the in-flight packet with no push and no drop_cnt increment; the first grant after reset goes to the lowest pending index.

Verification
REQ-032 pndng=4'b0001, D_pop[0]=16'h02AB, full=0 -> pop[0] at n+1, push=4'b0100 and D_push=16'h02AB at n+3, busy low at n+4.
REQ-033 pndng=4'b1111 held, all destinations valid -> grant order 0,1,2,3,0 with one push per 4 cycles.
REQ-034 Source 1 sends 16'hFF55 -> push=4'b1101, D_push=16'hFF55; source 1 never receives.
REQ-035 Destination 8'h07 or dest==source -> no push, drop_cnt increments by 1, next grant proceeds.
REQ-036 full[2]=1 for 10 cycles then 0, tmo=64 -> push to 2 on the cycle after full falls; full[2] held 64+ cycles -> drop, drop_cnt+1.
REQ-037 Assert reset during WAIT -> next cycle pop=push=busy=0, drop_cnt unchanged, no delivery of that packet.
